load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_align.sv | 27 ++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, funct3 codes,
// the default bus timeout and the access-size decode used by RTL sub-blocks.
package lsu_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_WAIT = 2'd2;
    localparam lsu_state_t ST_DONE = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

    // Unused encodings (011, 110, 111) fall through to a word access.
    function automatic acc_size_t size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a bus word and sign- or
// zero-extends it according to funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{offset, 3'b000} +: 8];
    assign lane_h = offset[1] ? word[31:16] : word[15:0];

    // NOTE: every path assigns result, so no latch is inferred.
    always_comb begin
        case (size_of(funct3))
            SZ_BYTE: result = funct3[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: result = funct3[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one aligned access from decode, issues it on the
// data bus, waits (bounded by TIMEOUT) for load data and reports completion.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        d_req_valid,
    input  logic        d_req_ready,
    output logic [31:0] d_req_addr,
    output logic        d_req_we,
    output logic [3:0]  d_req_be,
    output logic [31:0] d_req_wdata,
    input  logic        d_rsp_valid,
    input  logic [31:0] d_rsp_rdata
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    lsu_state_t  state;
    logic [31:0] addr_q, sdata_q, load_q, aligned;
    logic [2:0]  funct3_q;
    logic        is_load_q, err_q;
    logic [7:0]  wait_cnt;
    logic        req, mis, accept, in_req;
    acc_size_t   size_in, size_q;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    assign req     = memRead | memWrite;
    assign size_in = size_of(funct3);
    assign mis     = (size_in == SZ_HALF && addr[0]) ||
                     (size_in == SZ_WORD && addr[1:0] != 2'b00);
    assign accept  = (state == ST_IDLE) && req && !mis;
    assign in_req  = (state == ST_REQ);
    assign size_q  = size_of(funct3_q);

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = sdata_q;
        case (size_q)
            SZ_BYTE: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{sdata_q[7:0]}};
            end
            SZ_HALF: begin
                be_c    = 4'b0011 << addr_q[1:0];
                wdata_c = {2{sdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_align (
        .word   (d_rsp_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .result (aligned)
    );

    assign d_req_valid = in_req;
    assign d_req_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'b0;
    assign d_req_we    = in_req & ~is_load_q;
    assign d_req_be    = in_req ? be_c : 4'b0;
    assign d_req_wdata = in_req ? wdata_c : 32'b0;

    assign stall      = accept || in_req || (state == ST_WAIT);
    assign misaligned = (state == ST_IDLE) && req && mis;
    // A timed-out load still completes with load_valid, carrying zero data.
    assign load_valid = (state == ST_DONE) && is_load_q;
    assign bus_err    = (state == ST_DONE) && err_q;
    assign load_data  = load_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            funct3_q  <= '0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
            load_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    addr_q    <= addr;
                    sdata_q   <= store_data;
                    funct3_q  <= funct3;
                    is_load_q <= memRead;
                    err_q     <= 1'b0;
                    state     <= ST_REQ;
                end
                ST_REQ: if (d_req_ready) begin
                    wait_cnt <= '0;
                    state    <= is_load_q ? ST_WAIT : ST_DONE;
                end
                ST_WAIT: begin
                    if (d_rsp_valid) begin
                        load_q <= aligned;
                        state  <= ST_DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        load_q <= '0;
                        err_q  <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses compared every cycle against a transaction-level model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset, memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        load_valid, stall, misaligned, bus_err;
    logic        d_req_valid, d_req_ready, d_req_we;
    logic [31:0] d_req_addr, d_req_wdata;
    logic [3:0]  d_req_be;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data), .load_valid(load_valid), .stall(stall),
        .misaligned(misaligned), .bus_err(bus_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_addr(d_req_addr), .d_req_we(d_req_we), .d_req_be(d_req_be),
        .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid),
        .d_rsp_rdata(d_rsp_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, set by the driver.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_mis, exp_err, exp_lv, exp_reqv, exp_we;
    logic [31:0] exp_addr, exp_wd, exp_ld;
    logic [3:0]  exp_be;

    int n_stall = 0, n_lv = 0, n_mis = 0, n_err = 0, n_reqv = 0;
    logic [31:0] last_ld, last_addr, last_wd;
    logic [3:0]  last_be;
    logic        last_we;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("misaligned", 32'(misaligned), 32'(exp_mis));
            check("bus_err", 32'(bus_err), 32'(exp_err));
            check("load_valid", 32'(load_valid), 32'(exp_lv));
            check("d_req_valid", 32'(d_req_valid), 32'(exp_reqv));
            if (exp_reqv) begin
                check("d_req_addr", d_req_addr, exp_addr);
                check("d_req_we", 32'(d_req_we), 32'(exp_we));
                if (exp_we) begin
                    check("d_req_be", 32'(d_req_be), 32'(exp_be));
                    check("d_req_wdata", d_req_wdata, exp_wd);
                end
            end
            if (exp_lv) check("load_data", load_data, exp_ld);
            if (stall) n_stall++;
            if (misaligned) n_mis++;
            if (bus_err) n_err++;
            if (load_valid) begin
                n_lv++;
                last_ld = load_data;
            end
            if (d_req_valid) begin
                n_reqv++;
                last_addr = d_req_addr;
                last_be   = d_req_be;
                last_wd   = d_req_wdata;
                last_we   = d_req_we;
            end
        end
    end

    // ---------------- behavioural model ----------------
    function automatic int sz(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
        int n = sz(f3);
        logic [31:0] v;
        if (n == 4) return w;
        v = w >> (8 * int'(off));
        v = v & ((n == 1) ? 32'h0000_00FF : 32'h0000_FFFF);
        if (!f3[2] && v[8*n-1]) v = v | ((n == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be = 4'b0;
        int n = sz(f3);
        for (int i = 0; i < n; i++) be[int'(off) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] wd;
        int n = sz(f3);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % n) +: 8];
        return wd;
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        exp_stall = 1'b0; exp_mis = 1'b0; exp_err = 1'b0; exp_lv = 1'b0;
        exp_reqv = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
        exp_ld = '0; exp_be = '0;
    endtask

    task automatic idle(input int n);
        memRead = 1'b0; memWrite = 1'b0;
        d_req_ready = 1'b0; d_rsp_valid = 1'b0;
        clear_exp();
        for (int i = 0; i < n; i++) tick();
    endtask

    // rsp_dly = number of silent WAIT cycles before the response; >= TO means timeout.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rdata, input int rdy_dly,
                             input int rsp_dly, input logic done_req);
        int n = sz(f3);
        logic mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        logic to = 1'b0;
        memRead = rd; memWrite = wr; funct3 = f3; addr = a; store_data = sd;
        d_req_ready = 1'($urandom_range(0, 1));
        d_rsp_valid = 1'($urandom_range(0, 1));
        d_rsp_rdata = $urandom;
        clear_exp();
        exp_stall = !mis;
        exp_mis   = mis;
        tick();
        memRead = 1'b0; memWrite = 1'b0;
        addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
        if (mis) begin
            idle(0);
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            d_req_ready = (i == rdy_dly);
            d_rsp_valid = 1'($urandom_range(0, 1));
            d_rsp_rdata = $urandom;
            clear_exp();
            exp_stall = 1'b1; exp_reqv = 1'b1; exp_we = !rd;
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = m_be(f3, a[1:0]);
            exp_wd    = m_wdata(f3, sd);
            tick();
        end
        d_req_ready = 1'b0;
        if (rd) begin
            to = 1'b1;
            for (int i = 0; i < TO; i++) begin
                clear_exp();
                exp_stall = 1'b1;
                if (i == rsp_dly) begin
                    d_rsp_valid = 1'b1; d_rsp_rdata = rdata; to = 1'b0;
                end else begin
                    d_rsp_valid = 1'b0; d_rsp_rdata = $urandom;
                end
                tick();
                if (!to) break;
            end
        end
        d_rsp_valid = 1'($urandom_range(0, 1));
        d_rsp_rdata = $urandom;
        if (done_req) begin
            memRead = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040;
        end
        clear_exp();
        exp_lv  = rd;
        exp_err = rd && to;
        exp_ld  = to ? 32'h0 : m_load(f3, a[1:0], rdata);
        tick();
        idle(0);
    endtask

    int s_stall, s_lv, s_mis, s_err, s_reqv;
    task automatic snap();
        s_stall = n_stall; s_lv = n_lv; s_mis = n_mis; s_err = n_err; s_reqv = n_reqv;
    endtask

    initial begin
        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b0;
        addr = '0; store_data = '0; d_req_ready = 1'b0; d_rsp_valid = 1'b0;
        d_rsp_rdata = '0;
        clear_exp();
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        idle(2);

        // SW addr=0x100
        snap();
        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
        check("sw_be", 32'(last_be), 32'h0000_000F);
        check("sw_addr", last_addr, 32'h0000_0100);
        check("sw_wdata", last_wd, 32'hDEAD_BEEF);
        check("sw_we", 32'(last_we), 32'h1);
        check("sw_stall_cycles", 32'(n_stall - s_stall), 32'd2);
        check("sw_no_load_valid", 32'(n_lv - s_lv), 32'd0);
        idle(1);

        // LB addr=0x203, response after 3 silent WAIT cycles
        snap();
        do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FF7F, 1, 3, 1'b0);
        check("lb_data", last_ld, 32'hFFFF_FF80);
        check("lb_valid_pulses", 32'(n_lv - s_lv), 32'd1);
        check("lb_no_bus_err", 32'(n_err - s_err), 32'd0);
        idle(1);

        // SH addr=0x302
        do_access(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000_ABCD, 32'h0, 2, 0, 1'b0);
        check("sh_be", 32'(last_be), 32'h0000_000C);
        check("sh_wdata", last_wd, 32'hABCD_ABCD);
        idle(1);

        // LW addr=0x401 misaligned
        snap();
        do_access(1'b1, 1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 0, 0, 1'b0);
        idle(2);
        check("lw_mis_pulses", 32'(n_mis - s_mis), 32'd1);
        check("lw_mis_no_req", 32'(n_reqv - s_reqv), 32'd0);
        check("lw_mis_no_stall", 32'(n_stall - s_stall), 32'd0);

        // LHU timeout
        snap();
        do_access(1'b1, 1'b0, 3'b101, 32'h502, 32'h0, 32'h0, 0, 99, 1'b0);
        check("lhu_to_bus_err", 32'(n_err - s_err), 32'd1);
        check("lhu_to_data", last_ld, 32'h0);
        check("lhu_to_stall_cycles", 32'(n_stall - s_stall), 32'd6);
        idle(1);

        // LHU/LH/LBU lanes and load-wins-over-store
        do_access(1'b1, 1'b1, 3'b101, 32'h702, 32'h0, 32'h89AB_CDEF, 0, 0, 1'b1);
        check("lhu_data", last_ld, 32'h0000_89AB);
        check("both_is_load", 32'(last_we), 32'h0);
        do_access(1'b1, 1'b0, 3'b001, 32'h700, 32'h0, 32'h1234_8001, 1, 1, 1'b0);
        check("lh_data", last_ld, 32'hFFFF_8001);
        do_access(1'b1, 1'b0, 3'b100, 32'h701, 32'h0, 32'h0000_F100, 0, 2, 1'b0);
        check("lbu_data", last_ld, 32'h0000_00F1);
        do_access(1'b0, 1'b1, 3'b111, 32'h704, 32'h1357_9BDF, 32'h0, 0, 0, 1'b0);
        check("f3_111_word_be", 32'(last_be), 32'h0000_000F);

        // Reset in WAIT abandons the load
        snap();
        memRead = 1'b1; funct3 = 3'b010; addr = 32'h600;
        clear_exp(); exp_stall = 1'b1;
        tick();
        memRead = 1'b0; d_req_ready = 1'b1;
        clear_exp(); exp_stall = 1'b1; exp_reqv = 1'b1; exp_addr = 32'h600;
        tick();
        d_req_ready = 1'b0;
        clear_exp(); exp_stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_exp();
        tick();
        d_rsp_valid = 1'b1; d_rsp_rdata = 32'h1111_2222;
        tick();
        tick();
        d_rsp_valid = 1'b0;
        idle(1);
        check("rst_wait_no_load_valid", 32'(n_lv - s_lv), 32'd0);
        check("rst_wait_no_bus_err", 32'(n_err - s_err), 32'd0);
        check("rst_wait_single_req", 32'(n_reqv - s_reqv), 32'd1);

        // Randomized accesses
        for (int t = 0; t < 300; t++) begin
            logic rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            int n;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = 3'($urandom);
            n  = sz(f3);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (n == 2) a[0] = 1'b0;
                if (n == 4) a[1:0] = 2'b00;
            end
            do_access(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 5), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
